div_unit: RTL

//  Multi-cycle radix-2 restoring divider for the execute stage; serves DIV/DIVU flagged by the main decoder (isdiv, signeddiv).

---
 rtl/div_unit_if.sv | 29 ++
 rtl/div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between the execute stage and the divider
// Purpose: groups the divide request (start/signed_div/annul/a/b) and the
//          result side (stall/done/hi/lo) so the divider plugs in as one port.
// Ports (modports):
//   master : drives start, signed_div, annul, a, b; observes stall, done, hi, lo
//   slave  : the divider; observes the request, drives stall, done, hi, lo
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             annul;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_div, annul, a, b,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider (DIV/DIVU) with HI/LO result
// Purpose: one quotient bit per cycle, MSB first; stalls the pipeline while busy and
//          pulses done for one cycle with hi=remainder, lo=quotient.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : div_unit_if.slave (start, signed_div, annul, a, b -> stall, done, hi, lo)
// Build option: DIV_ZERO_FAST_EN - divide by zero skips the iterations and finishes
//               in the cycle after accept.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] rem_q,    rem_d;     // partial remainder
    logic [WIDTH-1:0] quo_q,    quo_d;     // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs_q,    dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] araw_q,   araw_d;    // untouched dividend, returned as remainder on divide by zero
    logic             qneg_q,   qneg_d;
    logic             rneg_q,   rneg_d;
    logic             dz_q,     dz_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;  // finished results waiting for the FIN commit
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             fin_ok;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        araw_d   = araw_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // One restoring step: a borrow out of the trial subtraction means rem < divisor.
        trial   = {rem_q, quo_q[WIDTH-1]};
        diff    = trial - {1'b0, dvs_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ge};

        // Magnitudes are plain WIDTH-bit negations, so the most negative value maps onto itself
        // and is then treated as an unsigned magnitude.
        a_neg = bus.signed_div & bus.a[WIDTH-1];
        b_neg = bus.signed_div & bus.b[WIDTH-1];
        abs_a = a_neg ? (~bus.a + ONE) : bus.a;
        abs_b = b_neg ? (~bus.b + ONE) : bus.b;

        fin_ok = (state_q == FIN) && !bus.annul;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.annul) begin
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    araw_d  = bus.a;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dz_d    = (bus.b == '0);
                    count_d = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.b == '0) begin
                        res_lo_d = '1;
                        res_hi_d = bus.a;
                        state_d  = FIN;
                    end else begin
                        state_d  = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (bus.annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_nxt;
                    quo_d   = quo_nxt;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_CNT) begin
                        state_d = FIN;
                        if (dz_q) begin
                            res_lo_d = '1;
                            res_hi_d = araw_q;
                        end else begin
                            res_lo_d = qneg_q ? (~quo_nxt + ONE) : quo_nxt;
                            res_hi_d = rneg_q ? (~rem_nxt + ONE) : rem_nxt;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!bus.annul) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            araw_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            araw_q   <= araw_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // done and the visible results depend on annul in the FIN cycle itself, so a flush
    // there hides the result immediately and the held hi/lo never change.
    assign bus.stall = ((state_q == IDLE) && bus.start && !bus.annul) || (state_q == CALC);
    assign bus.done  = fin_ok;
    assign bus.hi    = fin_ok ? res_hi_q : hi_q;
    assign bus.lo    = fin_ok ? res_lo_q : lo_q;
endmodule
